// File: rtl/apb_reg_slave.sv
// APB4 completer: byte-writable control registers, a read-only ID word and a
// completed-transfer counter, with a parameterised number of wait states.
module apb_reg_slave #(
   parameter int unsigned ADDR     = 32,
   parameter int unsigned PDATA    = 32,
   parameter int unsigned NREGS    = 8,
   parameter int unsigned WAIT     = 0,
   parameter logic [31:0] ID_VALUE = 32'h4150_4231
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               psel,
   input  logic               penable,
   input  logic [2:0]         pprot,
   input  logic [ADDR-1:0]    paddr,
   input  logic               pwrite,
   input  logic [PDATA/8-1:0] pstrb,
   input  logic [PDATA-1:0]   pwdata,
   output logic [PDATA-1:0]   prdata,
   output logic               pslverr,
   output logic               pready
);

   localparam int unsigned NLANES = PDATA / 8;
   localparam int unsigned WCNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   state_t            state;
   logic [WCNT_W-1:0] wait_cnt;
   logic [PDATA-1:0]  regs [NREGS];
   logic [PDATA-1:0]  xfer_cnt;

   logic [3:0]        word;
   logic              is_reg;
   logic              is_id;
   logic              is_cnt;
   logic              err;
   logic              done;
   logic              commit;
   logic [PDATA-1:0]  rdata;
   logic              unused_bits;

   assign word        = paddr[5:2];
   assign unused_bits = ^{paddr[ADDR-1:6], pprot[2:1]};

   // Address decode and error classification of the current access.
   always_comb begin
      is_reg = 1'b0;
      is_id  = 1'b0;
      is_cnt = 1'b0;
      err    = 1'b0;
      is_reg = ({1'b0, word} < 5'(NREGS));
      is_id  = ({1'b0, word} == 5'(NREGS));
      is_cnt = ({1'b0, word} == 5'(NREGS + 1));
      if (paddr[1:0] != 2'b00)
         err = 1'b1;
      if (!(is_reg || is_id || is_cnt))
         err = 1'b1;
      if (pwrite && (is_id || is_cnt))
         err = 1'b1;
      if (pwrite && is_reg && (word == 4'd0) && !pprot[0])
         err = 1'b1;
   end

   // Read mux over registers, ID and the transfer counter.
   always_comb begin
      rdata = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (is_reg && (word == 4'(i)))
            rdata = regs[i];
      end
      if (is_id)
         rdata = PDATA'(ID_VALUE);
      if (is_cnt)
         rdata = xfer_cnt;
   end

   assign done    = (state == ACCESS) && (wait_cnt == WCNT_W'(WAIT));
   assign commit  = done && !err;
   assign pready  = done;
   assign pslverr = done && err;
   assign prdata  = (done && !pwrite && !err) ? rdata : '0;

   // Transfer sequencing; dropping psel/penable mid-access aborts silently.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (psel && !penable)
                  state <= SETUP;
            end
            SETUP: begin
               state    <= ACCESS;
               wait_cnt <= '0;
            end
            ACCESS: begin
               if (done) begin
                  state    <= (psel && !penable) ? SETUP : IDLE;
                  wait_cnt <= '0;
               end else if (!(psel && penable)) begin
                  state    <= IDLE;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + WCNT_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   // Byte-lane register writes at the completion edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (commit && pwrite && is_reg) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            if (word == 4'(i)) begin
               for (int unsigned b = 0; b < NLANES; b++) begin
                  if (pstrb[b])
                     regs[i][8*b +: 8] <= pwdata[8*b +: 8];
               end
            end
         end
      end
   end

   // Counts every error-free completion, wrapping at the top.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         xfer_cnt <= '0;
      else if (commit)
         xfer_cnt <= xfer_cnt + PDATA'(1);
   end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: one instance with no wait states and one
// with three, sharing the APB bus except for their selects.
module tb_apb_reg_slave;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        psel0;
   logic        psel3;
   logic        penable;
   logic [2:0]  pprot;
   logic [31:0] paddr;
   logic        pwrite;
   logic [3:0]  pstrb;
   logic [31:0] pwdata;
   logic [31:0] prdata0;
   logic [31:0] prdata3;
   logic        pslverr0;
   logic        pslverr3;
   logic        pready0;
   logic        pready3;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   apb_reg_slave #(.WAIT(0)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .psel(psel0), .penable(penable),
      .pprot(pprot), .paddr(paddr), .pwrite(pwrite), .pstrb(pstrb),
      .pwdata(pwdata), .prdata(prdata0), .pslverr(pslverr0), .pready(pready0)
   );

   apb_reg_slave #(.WAIT(3)) u_dut3 (
      .clk(clk), .reset_n(reset_n), .psel(psel3), .penable(penable),
      .pprot(pprot), .paddr(paddr), .pwrite(pwrite), .pstrb(pstrb),
      .pwdata(pwdata), .prdata(prdata3), .pslverr(pslverr3), .pready(pready3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One APB transfer; lat counts cycles from the setup cycle to pready, 0 on timeout.
   task automatic xfer(input bit dut3, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic [2:0] prot, output logic [31:0] rd,
                       output logic er, output int lat);
      @(posedge clk); #1;
      psel0   = !dut3;
      psel3   = dut3;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wdata;
      pstrb   = strb;
      pprot   = prot;
      rd      = '0;
      er      = 1'b0;
      lat     = 0;
      @(posedge clk); #1;
      penable = 1'b1;
      for (int k = 1; (k <= 40) && (lat == 0); k++) begin
         @(negedge clk);
         if (dut3 ? pready3 : pready0) begin
            lat = k;
            rd  = dut3 ? prdata3 : prdata0;
            er  = dut3 ? pslverr3 : pslverr0;
         end else begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic xfer_chk(input string tag, input bit dut3, input bit wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot,
                           input logic [31:0] exp_rd, input logic exp_err);
      logic [31:0] rd;
      logic        er;
      int          lat;
      xfer(dut3, wr, addr, wdata, strb, prot, rd, er, lat);
      check({tag, " latency"}, 32'(lat), dut3 ? 32'd5 : 32'd2);
      check({tag, " pslverr"}, {31'd0, er}, {31'd0, exp_err});
      if (!wr)
         check({tag, " prdata"}, rd, exp_rd);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      psel0   = 1'b0;
      psel3   = 1'b0;
      penable = 1'b0;
      pprot   = 3'b000;
      paddr   = '0;
      pwrite  = 1'b0;
      pstrb   = '0;
      pwdata  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset pready0", {31'd0, pready0}, 32'd0);
      check("reset pslverr0", {31'd0, pslverr0}, 32'd0);
      check("reset prdata0", prdata0, 32'd0);
      check("reset pready3", {31'd0, pready3}, 32'd0);
      reset_n = 1'b1;

      // No wait states: data path, strobes, ID, errors, privilege, counter.
      xfer_chk("w04", 1'b0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0, 1'b0);
      xfer_chk("r04", 1'b0, 1'b0, 32'h04, 32'h0, 4'hF, 3'b000, 32'hDEADBEEF, 1'b0);
      xfer_chk("w08 full", 1'b0, 1'b1, 32'h08, 32'h11223344, 4'hF, 3'b000, 32'h0, 1'b0);
      xfer_chk("w08 strb5", 1'b0, 1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, 3'b000, 32'h0, 1'b0);
      xfer_chk("r08 merged", 1'b0, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 32'h11BB33DD, 1'b0);
      xfer_chk("r20 id", 1'b0, 1'b0, 32'h20, 32'h0, 4'hA, 3'b000, 32'h41504231, 1'b0);
      xfer_chk("w20 id", 1'b0, 1'b1, 32'h20, 32'h0, 4'hF, 3'b001, 32'h0, 1'b1);
      xfer_chk("r20 id again", 1'b0, 1'b0, 32'h20, 32'h0, 4'hF, 3'b000, 32'h41504231, 1'b0);
      xfer_chk("r3c unmapped", 1'b0, 1'b0, 32'h3C, 32'h0, 4'hF, 3'b000, 32'h0, 1'b1);
      xfer_chk("r05 misaligned", 1'b0, 1'b0, 32'h05, 32'h0, 4'hF, 3'b000, 32'h0, 1'b1);
      xfer_chk("w00 user", 1'b0, 1'b1, 32'h00, 32'hCAFEF00D, 4'hF, 3'b000, 32'h0, 1'b1);
      xfer_chk("r00 untouched", 1'b0, 1'b0, 32'h00, 32'h0, 4'hF, 3'b000, 32'h0, 1'b0);
      xfer_chk("w00 priv", 1'b0, 1'b1, 32'h00, 32'hCAFEF00D, 4'hF, 3'b001, 32'h0, 1'b0);
      xfer_chk("r00 landed", 1'b0, 1'b0, 32'h00, 32'h0, 4'hF, 3'b000, 32'hCAFEF00D, 1'b0);
      xfer_chk("w08 strb0", 1'b0, 1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, 3'b000, 32'h0, 1'b0);
      xfer_chk("r08 held", 1'b0, 1'b0, 32'h08, 32'h0, 4'hF, 3'b000, 32'h11BB33DD, 1'b0);
      xfer_chk("w24 cnt", 1'b0, 1'b1, 32'h24, 32'h0, 4'hF, 3'b000, 32'h0, 1'b1);
      xfer_chk("r24 cnt0", 1'b0, 1'b0, 32'h24, 32'h0, 4'hF, 3'b000, 32'd12, 1'b0);
      xfer_chk("r24 cnt1", 1'b0, 1'b0, 32'h24, 32'h0, 4'hF, 3'b000, 32'd13, 1'b0);

      // Three wait states: back-to-back reads and counter.
      for (int i = 0; i < 5; i++)
         xfer_chk($sformatf("w3 read%0d", i), 1'b1, 1'b0, 32'(4 * i), 32'h0, 4'hF,
                  3'b000, 32'h0, 1'b0);
      xfer_chk("w3 r24 a", 1'b1, 1'b0, 32'h24, 32'h0, 4'hF, 3'b000, 32'd5, 1'b0);

      // Dropping psel mid-access abandons the write and does not count.
      @(posedge clk); #1;
      psel0 = 1'b0; psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h10; pwdata = 32'h5A5A5A5A; pstrb = 4'hF; pprot = 3'b001;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      psel3 = 1'b0; penable = 1'b0;
      #1;
      check("abort pready", {31'd0, pready3}, 32'd0);
      xfer_chk("w3 r10 after abort", 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000, 32'h0, 1'b0);
      xfer_chk("w3 r24 b", 1'b1, 1'b0, 32'h24, 32'h0, 4'hF, 3'b000, 32'd7, 1'b0);
      xfer_chk("w3 w0c", 1'b1, 1'b1, 32'h0C, 32'h12345678, 4'hF, 3'b000, 32'h0, 1'b0);
      xfer_chk("w3 r0c", 1'b1, 1'b0, 32'h0C, 32'h0, 4'hF, 3'b000, 32'h12345678, 1'b0);

      // Reset during the access phase of a write.
      @(posedge clk); #1;
      psel0 = 1'b0; psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h0C; pwdata = 32'hFFFFFFFF; pstrb = 4'hF; pprot = 3'b000;
      @(posedge clk); #1;
      penable = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      check("pre-reset pready", {31'd0, pready3}, 32'd0);
      reset_n = 1'b0;
      #1;
      check("in-reset pready3", {31'd0, pready3}, 32'd0);
      check("in-reset pslverr3", {31'd0, pslverr3}, 32'd0);
      check("in-reset prdata3", prdata3, 32'd0);
      psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      xfer_chk("post-reset r24", 1'b1, 1'b0, 32'h24, 32'h0, 4'hF, 3'b000, 32'd0, 1'b0);
      xfer_chk("post-reset r0c", 1'b1, 1'b0, 32'h0C, 32'h0, 4'hF, 3'b000, 32'h0, 1'b0);
      xfer_chk("post-reset dut0 r04", 1'b0, 1'b0, 32'h04, 32'h0, 4'hF, 3'b000, 32'h0, 1'b0);

      @(posedge clk); #1;
      psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
